// File: rtl/mem_arbiter_pkg.sv
// Shared types and width helpers for the round-robin memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      READ_WAIT   = 3'd1,
      WRITE_WAIT  = 3'd2,
      READ_RELAY  = 3'd3,
      WRITE_RELAY = 3'd4
   } mem_arb_state_t;

   function automatic int unsigned line_bits(input int unsigned read_num,
                                             input int unsigned data_bits);
      return read_num * data_bits;
   endfunction

   function automatic int unsigned idx_bits(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

   localparam int unsigned DEFAULT_LINE_W = line_bits(32'd4, 32'd8);

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_picker
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 32'd4,
   parameter int unsigned IDX_W   = idx_bits(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_index
);

   // scan last_grant+1 .. last_grant+NUM_REQ; the first hit wins
   always_comb begin
      grant_valid = 1'b0;
      grant_index = {IDX_W{1'b0}};
      for (int unsigned k = 32'd1; k <= NUM_REQ; k++) begin
         if (!grant_valid && req[IDX_W'((32'(last_grant) + k) % NUM_REQ)]) begin
            grant_valid = 1'b1;
            grant_index = IDX_W'((32'(last_grant) + k) % NUM_REQ);
         end else begin
            grant_valid = grant_valid;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises consumer read/write requests onto one memory channel, round-robin.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned NUM_CONSUMERS = 32'd4,
   parameter int unsigned ADDR_BITS     = 32'd8,
   parameter int unsigned DATA_BITS     = 32'd8,
   parameter int unsigned READ_NUM      = 32'd4,
   parameter bit          WRITE_ENABLE  = 1'b1,
   localparam int unsigned LINE_W       = line_bits(READ_NUM, DATA_BITS),
   localparam int unsigned IDX_W        = idx_bits(NUM_CONSUMERS)
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
   output logic [NUM_CONSUMERS-1:0][LINE_W-1:0]    consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
   output logic                                    mem_read_valid,
   output logic [ADDR_BITS-1:0]                    mem_read_address,
   input  logic                                    mem_read_ready,
   input  logic [LINE_W-1:0]                       mem_read_data,
   output logic                                    mem_write_valid,
   output logic [ADDR_BITS-1:0]                    mem_write_address,
   output logic [DATA_BITS-1:0]                    mem_write_data,
   input  logic                                    mem_write_ready
);

   mem_arb_state_t             state_r;
   logic [IDX_W-1:0]           grant_r;
   logic [IDX_W-1:0]           last_grant_r;
   logic [NUM_CONSUMERS-1:0]   req_s;
   logic                       pick_valid_s;
   logic [IDX_W-1:0]           pick_index_s;

   // with the write path removed, writes never compete so write outputs stay 0
   assign req_s = consumer_read_valid |
                  (WRITE_ENABLE ? consumer_write_valid : {NUM_CONSUMERS{1'b0}});

   rr_picker #(
      .NUM_REQ (NUM_CONSUMERS),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req         (req_s),
      .last_grant  (last_grant_r),
      .grant_valid (pick_valid_s),
      .grant_index (pick_index_s)
   );

   // arbitration FSM and all registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r              <= IDLE;
         grant_r              <= {IDX_W{1'b0}};
         last_grant_r         <= IDX_W'(NUM_CONSUMERS - 32'd1);
         consumer_read_ready  <= {NUM_CONSUMERS{1'b0}};
         consumer_read_data   <= {(NUM_CONSUMERS*LINE_W){1'b0}};
         consumer_write_ready <= {NUM_CONSUMERS{1'b0}};
         mem_read_valid       <= 1'b0;
         mem_read_address     <= {ADDR_BITS{1'b0}};
         mem_write_valid      <= 1'b0;
         mem_write_address    <= {ADDR_BITS{1'b0}};
         mem_write_data       <= {DATA_BITS{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (pick_valid_s) begin
                  grant_r <= pick_index_s;
                  // a consumer asking for both is served its read first
                  if (consumer_read_valid[pick_index_s]) begin
                     mem_read_valid   <= 1'b1;
                     mem_read_address <= consumer_read_address[pick_index_s];
                     state_r          <= READ_WAIT;
                  end else begin
                     mem_write_valid   <= 1'b1;
                     mem_write_address <= consumer_write_address[pick_index_s];
                     mem_write_data    <= consumer_write_data[pick_index_s];
                     state_r           <= WRITE_WAIT;
                  end
               end
            end
            READ_WAIT: begin
               if (mem_read_ready) begin
                  mem_read_valid               <= 1'b0;
                  consumer_read_data[grant_r]  <= mem_read_data;
                  consumer_read_ready[grant_r] <= 1'b1;
                  state_r                      <= READ_RELAY;
               end
            end
            WRITE_WAIT: begin
               if (mem_write_ready) begin
                  mem_write_valid               <= 1'b0;
                  consumer_write_ready[grant_r] <= 1'b1;
                  state_r                       <= WRITE_RELAY;
               end
            end
            READ_RELAY: begin
               if (!consumer_read_valid[grant_r]) begin
                  consumer_read_ready[grant_r] <= 1'b0;
                  last_grant_r                 <= grant_r;
                  state_r                      <= IDLE;
               end
            end
            WRITE_RELAY: begin
               if (!consumer_write_valid[grant_r]) begin
                  consumer_write_ready[grant_r] <= 1'b0;
                  last_grant_r                  <= grant_r;
                  state_r                       <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level model and memory responder.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]       rv = 4'd0, wv = 4'd0;
   logic [3:0][7:0]  ra = '0, wa = '0, wd = '0;
   logic [3:0]       crr, cwr;
   logic [3:0][31:0] crd;
   logic             mrv, mwv;
   logic [7:0]       mra, mwa, mwd;
   logic             mrr_r, mwr_r;
   logic             force_rr = 1'b0, force_wr = 1'b0;
   logic             mrr_s, mwr_s;
   logic [31:0]      mrd = 32'd0;
   assign mrr_s = mrr_r | force_rr;
   assign mwr_s = mwr_r | force_wr;

   mem_arbiter dut (
      .clk (clk), .reset (reset_n),
      .consumer_read_valid (rv), .consumer_read_address (ra),
      .consumer_read_ready (crr), .consumer_read_data (crd),
      .consumer_write_valid (wv), .consumer_write_address (wa),
      .consumer_write_data (wd), .consumer_write_ready (cwr),
      .mem_read_valid (mrv), .mem_read_address (mra),
      .mem_read_ready (mrr_s), .mem_read_data (mrd),
      .mem_write_valid (mwv), .mem_write_address (mwa),
      .mem_write_data (mwd), .mem_write_ready (mwr_s)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- memory responder ----------------
   logic [7:0] mem [256];
   int         stall = 0;
   int         rcnt, wcnt;
   logic [7:0] last_wa, last_wd;

   function automatic logic [31:0] line_of(input logic [7:0] a);
      logic [31:0] l;
      for (int i = 0; i < 4; i++) l[i*8 +: 8] = mem[a + 8'(i)];
      return l;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mrr_r <= 1'b0; mwr_r <= 1'b0; rcnt <= 0; wcnt <= 0;
         last_wa <= 8'd0; last_wd <= 8'd0;
         for (int a = 0; a < 256; a++) mem[a] <= 8'(a) ^ 8'h5A;
         mem[8'h10] <= 8'h01; mem[8'h11] <= 8'h02;
         mem[8'h12] <= 8'h03; mem[8'h13] <= 8'h04;
      end else begin
         if (mrr_r) mrr_r <= 1'b0;
         else if (mrv) begin
            if (rcnt >= stall) begin mrr_r <= 1'b1; mrd <= line_of(mra); rcnt <= 0; end
            else rcnt <= rcnt + 1;
         end
         if (mwr_r) mwr_r <= 1'b0;
         else if (mwv) begin
            if (wcnt >= stall) begin
               mwr_r <= 1'b1; mem[mwa] <= mwd; last_wa <= mwa; last_wd <= mwd; wcnt <= 0;
            end else wcnt <= wcnt + 1;
         end
      end
   end

   // ---------------- transaction-level model ----------------
   bit          m_busy, m_wait, m_is_read;
   int          m_cons, m_last, pick_s;
   logic [7:0]  m_addr, m_wdata;
   logic [31:0] m_rdata [4];

   function automatic int rr_next(input int last, input logic [3:0] req);
      for (int k = 1; k <= 4; k++) if (req[(last + k) % 4]) return (last + k) % 4;
      return -1;
   endfunction
   assign pick_s = rr_next(m_last, rv | wv);

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_busy <= 1'b0; m_wait <= 1'b0; m_is_read <= 1'b0; m_cons <= 0; m_last <= 3;
         m_addr <= 8'd0; m_wdata <= 8'd0;
         for (int i = 0; i < 4; i++) m_rdata[i] <= 32'd0;
      end else if (!m_busy) begin
         if (pick_s >= 0) begin
            m_busy <= 1'b1; m_wait <= 1'b1; m_cons <= pick_s; m_is_read <= rv[pick_s];
            m_addr <= rv[pick_s] ? ra[pick_s] : wa[pick_s]; m_wdata <= wd[pick_s];
         end
      end else if (m_wait) begin
         if (m_is_read ? mrr_s : mwr_s) begin
            m_wait <= 1'b0;
            if (m_is_read) m_rdata[m_cons] <= line_of(m_addr);
         end
      end else if (!(m_is_read ? rv[m_cons] : wv[m_cons])) begin
         m_busy <= 1'b0; m_last <= m_cons;
      end
   end

   // consumers may only drop valid while their ready is visible
   logic [3:0] prev_rv = 4'd0, prev_wv = 4'd0;
   always @(posedge clk) begin
      prev_rv <= rv; prev_wv <= wv;
      for (int i = 0; i < 4; i++) begin
         assert (!(reset_n && prev_rv[i] && !rv[i] && !crr[i]))
            else $error("protocol: consumer %0d dropped read valid early", i);
         assert (!(reset_n && prev_wv[i] && !wv[i] && !cwr[i]))
            else $error("protocol: consumer %0d dropped write valid early", i);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- consumer agents ----------------
   int          rd_left [4] = '{0, 0, 0, 0};
   int          wr_left [4] = '{0, 0, 0, 0};
   int          rd_hold [4] = '{0, 0, 0, 0};
   int          hcnt [4], rd_t0 [4];
   bit          rd_got [4];
   logic [7:0]  rd_base [4];
   int          ev_q [$];
   logic [31:0] rd_res_q [$];
   int          lat_q [$];
   int          mrv_cnt = 0;
   int          rdy_cnt [4] = '{0, 0, 0, 0};

   task automatic agent();
      for (int i = 0; i < 4; i++) begin
         if (rv[i]) begin
            if (crr[i]) begin
               if (!rd_got[i]) begin
                  rd_got[i] = 1'b1; ev_q.push_back(i); rd_res_q.push_back(crd[i]);
                  lat_q.push_back(cyc - rd_t0[i]); hcnt[i] = rd_hold[i];
               end
               if (hcnt[i] == 0) begin rv[i] = 1'b0; rd_left[i]--; end
               else hcnt[i]--;
            end
         end else if (rd_left[i] > 0) begin
            rv[i] = 1'b1; ra[i] = rd_base[i]; rd_got[i] = 1'b0; rd_t0[i] = cyc;
         end
         if (wv[i]) begin
            if (cwr[i]) begin ev_q.push_back(8 + i); wv[i] = 1'b0; wr_left[i]--; end
         end else if (wr_left[i] > 0) begin
            wv[i] = 1'b1;
         end
      end
   endtask

   task automatic step1();
      @(posedge clk); #1; agent();
   endtask

   function automatic bit all_done();
      bit d = (rv == 4'd0) && (wv == 4'd0);
      for (int i = 0; i < 4; i++) if (rd_left[i] != 0 || wr_left[i] != 0) d = 1'b0;
      return d;
   endfunction

   task automatic run_until_done(input string name, input int budget);
      int n = 0;
      while (n < budget && !all_done()) begin step1(); n++; end
      checks++;
      if (!all_done()) begin
         failures++;
         $display("FAIL %s: not done after %0d cycles", name, budget);
      end
      repeat (3) step1();
   endtask

   function automatic logic [31:0] pack_ev();
      logic [31:0] r = 32'd0;
      for (int k = 0; k < ev_q.size() && k < 8; k++) r[k*4 +: 4] = 4'(ev_q[k]);
      return r;
   endfunction

   task automatic check_order(input string name, input int n, input logic [31:0] exp);
      chk({name, "_count"}, 32'(ev_q.size()), 32'(n));
      chk(name, pack_ev(), exp);
      ev_q.delete(); rd_res_q.delete(); lat_q.delete();
   endtask

   task automatic compare_cycle();
      bit exp_mrv = m_busy && m_wait && m_is_read;
      bit exp_mwv = m_busy && m_wait && !m_is_read;
      logic [3:0] exp_crr = (m_busy && !m_wait && m_is_read) ? (4'd1 << m_cons) : 4'd0;
      logic [3:0] exp_cwr = (m_busy && !m_wait && !m_is_read) ? (4'd1 << m_cons) : 4'd0;
      if (mrv) mrv_cnt++;
      for (int i = 0; i < 4; i++) if (crr[i]) rdy_cnt[i]++;
      chk("mem_read_valid", 32'(mrv), 32'(exp_mrv));
      chk("mem_write_valid", 32'(mwv), 32'(exp_mwv));
      chk("single_mem_op", 32'(mrv & mwv), 32'd0);
      if (exp_mrv) chk("mem_read_address", 32'(mra), 32'(m_addr));
      if (exp_mwv) begin
         chk("mem_write_address", 32'(mwa), 32'(m_addr));
         chk("mem_write_data", 32'(mwd), 32'(m_wdata));
      end
      chk("consumer_read_ready", 32'(crr), 32'(exp_crr));
      chk("consumer_write_ready", 32'(cwr), 32'(exp_cwr));
      for (int i = 0; i < 4; i++) chk("consumer_read_data", crd[i], m_rdata[i]);
   endtask

   int snap;

   initial begin
      fork
         forever begin @(negedge clk); compare_cycle(); end
      join_none

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rd_ready", 32'(crr), 32'd0);
      chk("reset_wr_ready", 32'(cwr), 32'd0);
      chk("reset_mem_valids", 32'({mrv, mwv}), 32'd0);
      chk("reset_mem_addr_data", {8'd0, mra, mwa, mwd}, 32'd0);
      for (int i = 0; i < 4; i++) chk("reset_rd_data", crd[i], 32'd0);
      reset_n = 1'b1;
      step1();

      // single read by consumer 2, held 2 extra cycles after ready
      rd_left[2] = 1; rd_base[2] = 8'h10; rd_hold[2] = 2; snap = rdy_cnt[2];
      run_until_done("single_read", 50);
      chk("single_read_data", rd_res_q[0], 32'h04030201);
      chk("single_read_latency", 32'(lat_q[0]), 32'd3);
      chk("single_read_ready_cycles", 32'(rdy_cnt[2] - snap), 32'd3);
      check_order("single_read_order", 1, 32'h2);
      rd_hold[2] = 0;

      // single write by consumer 1
      wr_left[1] = 1; wa[1] = 8'h05; wd[1] = 8'h2A;
      run_until_done("single_write", 50);
      chk("write_mem5", 32'(mem[8'h05]), 32'h2A);
      chk("write_addr_seen", 32'(last_wa), 32'h05);
      chk("write_data_seen", 32'(last_wd), 32'h2A);
      check_order("single_write_order", 1, 32'h9);

      // reset while consumer 3 is stalled in the read wait; 0 must then win first
      stall = 5;
      rd_left[0] = 1; rd_base[0] = 8'h20; rd_left[3] = 1; rd_base[3] = 8'h30;
      repeat (4) step1();
      chk("pre_reset_valid", 32'(mrv), 32'd1);
      chk("pre_reset_addr", 32'(mra), 32'h30);
      reset_n = 1'b0; stall = 0;
      #2;
      chk("async_reset_mem_valid", 32'({mrv, mwv}), 32'd0);
      chk("async_reset_ready", 32'({crr, cwr}), 32'd0);
      chk("async_reset_data2", crd[2], 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      run_until_done("reset_reissue", 60);
      check_order("reset_reissue_order", 2, 32'h30);

      // fairness: everyone re-requests immediately; consumer 3 wraps past 0xFF
      rd_base[0] = 8'h10; rd_base[1] = 8'h40; rd_base[2] = 8'h80; rd_base[3] = 8'hFE;
      for (int i = 0; i < 4; i++) rd_left[i] = 2;
      run_until_done("fairness", 200);
      chk("wrap_line_data", rd_res_q[3], 32'h5B5AA5A4);
      check_order("fairness_order", 8, 32'h32103210);

      // consumer 0 read+write with consumer 1 read pending
      rd_left[0] = 1; wr_left[0] = 1; wa[0] = 8'h07; wd[0] = 8'hC3; rd_left[1] = 1;
      run_until_done("read_write_same", 100);
      chk("rw_mem7", 32'(mem[8'h07]), 32'hC3);
      check_order("read_write_order", 3, 32'h810);

      // memory stall of 5 cycles
      stall = 5; rd_left[1] = 1; rd_base[1] = 8'h12; snap = mrv_cnt;
      run_until_done("stall", 60);
      chk("stall_latency", 32'(lat_q[0]), 32'd8);
      chk("stall_valid_cycles", 32'(mrv_cnt - snap), 32'd7);
      chk("stall_data", rd_res_q[0], 32'h4F4E0403);
      check_order("stall_order", 1, 32'h1);
      stall = 0;

      // memory readies while idle must be ignored
      force_rr = 1'b1; force_wr = 1'b1;
      repeat (2) step1();
      chk("spurious_ready_rd", 32'(crr), 32'd0);
      chk("spurious_ready_wr", 32'(cwr), 32'd0);
      force_rr = 1'b0; force_wr = 1'b0;
      repeat (2) step1();
      chk("spurious_no_events", 32'(ev_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
